// File: rtl/dot_pkg.sv
// Shared definitions for the dot-product sequencer: FSM state encoding and
// the default sizing constants used by dot_seq.
package dot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    HOLD
  } dotState_t;

  localparam int DefArraySize    = 4;
  localparam int DefAddressWidth = 2;
  localparam int DefZBits        = 28;
  localparam int DefMacLatency   = 1;

endpackage

// File: rtl/dot_seq.sv
// Sequencer for an external multiply-accumulate datapath: walks the element
// index, waits for the MAC pipeline to settle, then presents the sum on a
// valid/ready output.
module dot_seq
  import dot_pkg::*;
#(
  parameter int arraySize    = DefArraySize,
  parameter int addressWidth = DefAddressWidth,
  parameter int zBits        = DefZBits,
  parameter int macLatency   = DefMacLatency
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic [addressWidth-1:0] selector,
  output logic                    clear,
  input  logic [zBits-1:0]        z_in,
  output logic [zBits-1:0]        result,
  output logic                    result_valid,
  input  logic                    result_ready
);

  localparam int drainBits = $clog2(macLatency + 1);
  localparam logic [addressWidth-1:0] lastIndex = addressWidth'(arraySize - 1);
  localparam logic [drainBits-1:0]    drainLast = drainBits'(macLatency - 1);

  dotState_t               stateQ, stateD;
  logic [addressWidth-1:0] indexQ, indexD;
  logic [drainBits-1:0]    drainQ, drainD;
  logic [zBits-1:0]        resultQ, resultD;

  // Reset clears everything, so an aborted product never leaves a stale sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ  <= IDLE;
      indexQ  <= '0;
      drainQ  <= '0;
      resultQ <= '0;
    end else begin
      stateQ  <= stateD;
      indexQ  <= indexD;
      drainQ  <= drainD;
      resultQ <= resultD;
    end
  end

  always_comb begin
    stateD       = stateQ;
    indexD       = indexQ;
    drainD       = drainQ;
    resultD      = resultQ;
    selector     = '0;
    clear        = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;

    case (stateQ)
      IDLE: begin
        if (start) begin
          stateD = ISSUE;
          indexD = '0;
        end
      end

      ISSUE: begin
        busy     = 1'b1;
        selector = indexQ;
        clear    = (indexQ == '0);
        if (indexQ == lastIndex) begin
          stateD = DRAIN;
          indexD = '0;
          drainD = '0;
        end else begin
          indexD = indexQ + 1'b1;
        end
      end

      // z_in is only trustworthy once the last element has cleared the MAC pipe.
      DRAIN: begin
        busy = 1'b1;
        if (drainQ == drainLast) begin
          resultD = z_in;
          stateD  = HOLD;
          drainD  = '0;
        end else begin
          drainD = drainQ + 1'b1;
        end
      end

      HOLD: begin
        result_valid = 1'b1;
        if (result_ready) begin
          stateD = start ? ISSUE : IDLE;
          indexD = '0;
        end
      end

      default: stateD = IDLE;
    endcase
  end

  assign result = resultQ;

endmodule

// File: tb/tb_dot_seq.sv
// Self-checking bench for dot_seq: a registered MAC stands in for the datapath
// and every product is compared against a plain sum of element products.
module tb_dot_seq;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int ZB = 28;
  localparam int ML = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic [AW-1:0] selector;
  logic          clear;
  logic [ZB-1:0] z_in;
  logic [ZB-1:0] result;
  logic          result_valid;
  logic          result_ready;

  logic [ZB-1:0] zReg;
  int            aMem [N];
  int            bMem [N];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  dot_seq #(
    .arraySize   (N),
    .addressWidth(AW),
    .zBits       (ZB),
    .macLatency  (ML)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .selector    (selector),
    .clear       (clear),
    .z_in        (z_in),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready)
  );

  // Stand-in datapath: registered multiply-accumulate, restarted by clear.
  always @(posedge clk) begin
    if (rst) zReg <= '0;
    else if (clear) zReg <= ZB'(aMem[selector] * bMem[selector]);
    else zReg <= zReg + ZB'(aMem[selector] * bMem[selector]);
  end

  assign z_in = zReg;

  function automatic int refDot();
    int s = 0;
    for (int i = 0; i < N; i++) s += aMem[i] * bMem[i];
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_valid"}, 32'(result_valid), 32'd0);
    checkOutput({tag, "_sel"}, 32'(selector), 32'd0);
    checkOutput({tag, "_clear"}, 32'(clear), 32'd0);
  endtask

  // One full product: optional start pulse, issue, drain, hold with backpressure,
  // then the transfer (optionally chaining straight into the next product).
  task automatic applyStimulus(input bit fromIdle, input int expected, input int holdDelay,
                               input bit stray, input bit chain);
    if (fromIdle) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      checkOutput("issue_sel", 32'(selector), 32'(k));
      checkOutput("issue_clear", 32'(clear), (k == 0) ? 32'd1 : 32'd0);
      checkOutput("issue_busy", 32'(busy), 32'd1);
      checkOutput("issue_valid", 32'(result_valid), 32'd0);
      start        = stray && (k == 1);
      result_ready = 1'($urandom_range(0, 1));
      tick();
    end
    for (int d = 0; d < ML; d++) begin
      checkOutput("drain_busy", 32'(busy), 32'd1);
      checkOutput("drain_sel", 32'(selector), 32'd0);
      checkOutput("drain_clear", 32'(clear), 32'd0);
      checkOutput("drain_valid", 32'(result_valid), 32'd0);
      start        = stray;
      result_ready = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
    for (int h = 0; h < holdDelay; h++) begin
      checkOutput("hold_valid", 32'(result_valid), 32'd1);
      checkOutput("hold_result", 32'(result), 32'(expected));
      checkOutput("hold_busy", 32'(busy), 32'd0);
      result_ready = 1'b0;
      start        = stray;
      tick();
    end
    checkOutput("xfer_valid", 32'(result_valid), 32'd1);
    checkOutput("xfer_result", 32'(result), 32'(expected));
    checkOutput("xfer_busy", 32'(busy), 32'd0);
    checkOutput("xfer_sel", 32'(selector), 32'd0);
    result_ready = 1'b1;
    start        = chain;
    tick();
    result_ready = 1'b0;
    start        = 1'b0;
    if (!chain) checkQuiet("post_xfer");
  endtask

  task automatic loadBasic();
    for (int i = 0; i < N; i++) begin
      aMem[i] = i + 1;
      bMem[i] = i + 5;
    end
  endtask

  initial begin
    bit chained;
    bit chainNext;

    rst          = 1'b1;
    start        = 1'b0;
    result_ready = 1'b0;
    loadBasic();
    @(negedge clk);
    start        = 1'b1;
    result_ready = 1'b1;
    tick();
    checkQuiet("reset");
    checkOutput("reset_result", 32'(result), 32'd0);
    start        = 1'b0;
    result_ready = 1'b0;
    rst          = 1'b0;
    tick();
    checkQuiet("idle");

    // Basic product with five cycles of backpressure, chained into a second vector.
    applyStimulus(1'b1, 70, 5, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) begin
      aMem[i] = 2;
      bMem[i] = 3;
    end
    applyStimulus(1'b0, 24, 0, 1'b0, 1'b0);

    // Starts during ISSUE, DRAIN and stalled HOLD must not spawn a second product.
    loadBasic();
    applyStimulus(1'b1, 70, 2, 1'b1, 1'b0);
    tick();
    checkQuiet("no_second");

    // Reset in cycle 3 aborts the product; a restart must begin from a clean sum.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkQuiet("abort");
    checkOutput("abort_result", 32'(result), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 70, 0, 1'b0, 1'b0);

    // Reset while holding a result outranks a simultaneous transfer and start.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < N + ML; c++) tick();
    checkOutput("hold_before_rst", 32'(result_valid), 32'd1);
    rst          = 1'b1;
    result_ready = 1'b1;
    start        = 1'b1;
    tick();
    checkQuiet("hold_rst");
    checkOutput("hold_rst_result", 32'(result), 32'd0);
    rst          = 1'b0;
    result_ready = 1'b0;
    start        = 1'b0;
    tick();
    checkQuiet("after_hold_rst");

    chained = 1'b0;
    for (int iter = 0; iter < 25; iter++) begin
      for (int i = 0; i < N; i++) begin
        aMem[i] = int'($urandom_range(0, 255));
        bMem[i] = int'($urandom_range(0, 255));
      end
      chainNext = (iter < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
      applyStimulus(!chained, refDot(), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), chainNext);
      chained = chainNext;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
